rom_seq_reader: RTL and testbench

Parametrised lookup ROM with a built-in address sequencer. It replaces one-shot combinational ROM reads with burst reads. A single start request streams a run of consecutive ROM words over a valid/ready interface. The block supports wrap-around, loop mode, select gating and back-pressure. It sits between the control counter logic and any consumer that needs a stream of table values.

---
 rtl/rom_seq_reader.sv | 137 +++++++++++++
 tb/tb_rom_seq_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_seq_reader.sv
// Constant-content lookup ROM streamed as bursts over valid/ready.
// Optional parity output enabled by defining ROM_SEQ_PARITY_EN.
module rom_seq_reader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int OFFSET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic              loop,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr_out,
    output logic              last,
`ifdef ROM_SEQ_PARITY_EN
    output logic              parity,
`endif
    output logic              busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    function automatic logic [DATA_W-1:0] rom_entry(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) + DATA_W'(OFFSET);
    endfunction

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              loop_q, loop_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        len_d   = len_q;
        loop_d  = loop_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (!sel) begin
            state_d = S_IDLE;
            addr_d  = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                state_d = S_RUN;
                base_d  = start_addr;
                len_d   = len;
                loop_d  = loop;
                addr_d  = start_addr;
                cnt_d   = '0;
                valid_d = 1'b1;
                last_d  = (len == '0);
            end
        end else if (out_ready) begin
            if (cnt_q == len_q) begin
                // loop restarts without a bubble; otherwise the pass ends
                if (loop_q) begin
                    addr_d = base_q;
                    cnt_d  = '0;
                    last_d = (len_q == '0);
                end else begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end else begin
                addr_d = addr_q + ONE;
                cnt_d  = cnt_q + ONE;
                last_d = ((cnt_q + ONE) == len_q);
            end
        end
        data_d = valid_d ? rom_entry(addr_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

`ifdef ROM_SEQ_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^data_d;
        end
    end

    assign parity = parity_q;
`endif

    assign out_valid = valid_q;
    assign data      = data_q;
    assign addr_out  = addr_q;
    assign last      = last_q;
    assign busy      = (state_q == S_RUN);

endmodule

// File: tb/tb_rom_seq_reader.sv
// Directed bench for rom_seq_reader (ADDR_W=3, DATA_W=8, OFFSET=1).
// Parity checks are compiled in when ROM_SEQ_PARITY_EN is defined.
module tb_rom_seq_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       start = 1'b0;
    logic [2:0] start_addr = '0;
    logic [2:0] len = '0;
    logic       loop = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] data;
    logic [2:0] addr_out;
    logic       last;
    logic       busy;
`ifdef ROM_SEQ_PARITY_EN
    logic       parity;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] BASIC_D [4] = '{8'd3, 8'd4, 8'd5, 8'd6};
    localparam logic [7:0] WRAP_D  [4] = '{8'd7, 8'd8, 8'd1, 8'd2};
    localparam logic [2:0] WRAP_A  [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    localparam logic [7:0] BP_D    [6] = '{8'd3, 8'd4, 8'd4, 8'd4, 8'd5, 8'd6};
    localparam logic       BP_RDY  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    rom_seq_reader #(.ADDR_W(3), .DATA_W(8), .OFFSET(1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sel(sel),
        .start(start),
        .start_addr(start_addr),
        .len(len),
        .loop(loop),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .data(data),
        .addr_out(addr_out),
        .last(last),
`ifdef ROM_SEQ_PARITY_EN
        .parity(parity),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [2:0] sa, input logic [2:0] l, input logic lp);
        sel        = 1'b1;
        out_ready  = 1'b1;
        start      = 1'b1;
        start_addr = sa;
        len        = l;
        loop       = lp;
        step();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            sel        = 1'($urandom);
            start      = 1'($urandom);
            start_addr = 3'($urandom);
            len        = 3'($urandom);
            loop       = 1'($urandom);
            out_ready  = 1'($urandom);
            step();
            checks++;
            if (out_valid !== 1'b0 || data !== 8'd0 || addr_out !== 3'd0 ||
                last !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: valid=%b data=%0d addr=%0d last=%b busy=%b, want all 0",
                         i, out_valid, data, addr_out, last, busy);
            end
        end
        start = 1'b0;
        sel   = 1'b1;
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || data !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: valid=%b data=%0d busy=%b, want 0 0 0",
                     out_valid, data, busy);
        end
    endtask

    task automatic test_basic();
        kick(3'd2, 3'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || data !== BASIC_D[i] ||
                addr_out !== 3'(2 + i) || last !== (i == 3)) begin
                errors++;
                $display("FAIL basic[%0d]: valid=%b busy=%b data=%0d addr=%0d last=%b, want 1 1 %0d %0d %b",
                         i, out_valid, busy, data, addr_out, last, BASIC_D[i], 3'(2 + i), (i == 3));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || data !== 8'd0 || addr_out !== 3'd0) begin
            errors++;
            $display("FAIL basic_end: valid=%b busy=%b data=%0d addr=%0d, want 0 0 0 0",
                     out_valid, busy, data, addr_out);
        end
    endtask

    task automatic test_wrap();
        kick(3'd6, 3'd3, 1'b0);
`ifdef ROM_SEQ_PARITY_EN
        checks++;
        if (parity !== 1'b1) begin
            errors++;
            $display("FAIL parity_7: got %b, want 1", parity);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || data !== WRAP_D[i] || addr_out !== WRAP_A[i] ||
                last !== (i == 3)) begin
                errors++;
                $display("FAIL wrap[%0d]: valid=%b data=%0d addr=%0d last=%b, want 1 %0d %0d %b",
                         i, out_valid, data, addr_out, last, WRAP_D[i], WRAP_A[i], (i == 3));
            end
            step();
        end
`ifdef ROM_SEQ_PARITY_EN
        checks++;
        if (parity !== 1'b0) begin
            errors++;
            $display("FAIL parity_idle: got %b, want 0", parity);
        end
`endif
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        kick(3'd2, 3'd3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || data !== BP_D[i] || last !== (i == 5)) begin
                errors++;
                $display("FAIL bp[%0d]: valid=%b data=%0d last=%b, want 1 %0d %b",
                         i, out_valid, data, last, BP_D[i], (i == 5));
            end
            out_ready = BP_RDY[i];
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_loop_abort();
        logic [7:0] exp_d;
        kick(3'd0, 3'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            exp_d = (i % 2 == 0) ? 8'd1 : 8'd2;
            checks++;
            if (out_valid !== 1'b1 || data !== exp_d || last !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL loop[%0d]: valid=%b data=%0d last=%b, want 1 %0d %b",
                         i, out_valid, data, last, exp_d, (i % 2 == 1));
            end
            if (i == 4) sel = 1'b0;
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || data !== 8'd0 || busy !== 1'b0 || last !== 1'b0) begin
            errors++;
            $display("FAIL abort: valid=%b data=%0d busy=%b last=%b, want 0 0 0 0",
                     out_valid, data, busy, last);
        end
        sel = 1'b1;
        step();
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reselect_idle: valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_ignored_start();
        kick(3'd2, 3'd3, 1'b0);
        start      = 1'b1;
        start_addr = 3'd5;
        len        = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) start = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || data !== BASIC_D[i] || addr_out !== 3'(2 + i)) begin
                errors++;
                $display("FAIL ign_start[%0d]: valid=%b data=%0d addr=%0d, want 1 %0d %0d",
                         i, out_valid, data, addr_out, BASIC_D[i], 3'(2 + i));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_end: valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_async_reset();
        kick(3'd2, 3'd3, 1'b1);
        step();
        checks++;
        if (data !== 8'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: data=%0d busy=%b, want 4 1", data, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || data !== 8'd0 || addr_out !== 3'd0 ||
            last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arst: valid=%b data=%0d addr=%0d last=%b busy=%b, want all 0",
                     out_valid, data, addr_out, last, busy);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_after: valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_full_rom();
        logic [2:0] exp_a;
        kick(3'd5, 3'd7, 1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_a = 3'((5 + i) % 8);
            checks++;
            if (out_valid !== 1'b1 || addr_out !== exp_a ||
                data !== ({5'd0, exp_a} + 8'd1) || last !== (i == 7)) begin
                errors++;
                $display("FAIL full[%0d]: valid=%b data=%0d addr=%0d last=%b, want 1 %0d %0d %b",
                         i, out_valid, data, addr_out, last, {5'd0, exp_a} + 8'd1, exp_a, (i == 7));
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_end: valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_single_beat();
        kick(3'd4, 3'd0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || data !== 8'd5 || addr_out !== 3'd4 || last !== 1'b1) begin
            errors++;
            $display("FAIL single: valid=%b data=%0d addr=%0d last=%b, want 1 5 4 1",
                     out_valid, data, addr_out, last);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_loop_abort();
        test_ignored_start();
        test_async_reset();
        test_full_rom();
        test_single_beat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
